// File: rtl/lmem_pkg.sv
// Shared constants and types for the layer-memory port arbiter.
package lmem_pkg;
  localparam int LMEM_AW = 12;
  localparam int LMEM_DW = 13;

  localparam logic LMEM_L0 = 1'b0;
  localparam logic LMEM_L1 = 1'b1;

  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_OWN  = 1'b1;

  typedef struct packed {
    logic               we;
    logic               sel;
    logic [LMEM_AW-1:0] addr;
    logic [LMEM_DW-1:0] wdata;
    logic               last;
  } lmem_beat_t;
endpackage

// File: rtl/lmem_port_arbiter_if.sv
// Client and memory-side signals of the layer-memory port arbiter.
// Handshake: a client beat transfers in every cycle where reqK and gntK are both high; gntK never depends on reqK in the same cycle.
interface lmem_port_arbiter_if
  import lmem_pkg::*;
#(
  parameter int AW = LMEM_AW,
  parameter int DW = LMEM_DW
) ();
  logic          req0, we0, sel0, last0, gnt0, rvalid0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0, rdata0;
  logic          req1, we1, sel1, last1, gnt1, rvalid1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1, rdata1;
  logic          cwr, crd, csel;
  logic [AW-1:0] caddr_wr, caddr_rd;
  logic [DW-1:0] cdata_wr, cdata_rd;
  logic [0:0]    arb_state;

  modport master (
    output req0, we0, sel0, addr0, wdata0, last0,
    output req1, we1, sel1, addr1, wdata1, last1,
    output cdata_rd,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
    input  cwr, crd, csel, caddr_wr, caddr_rd, cdata_wr, arb_state
  );

  modport slave (
    input  req0, we0, sel0, addr0, wdata0, last0,
    input  req1, we1, sel1, addr1, wdata1, last1,
    input  cdata_rd,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
    output cwr, crd, csel, caddr_wr, caddr_rd, cdata_wr, arb_state
  );
endinterface

// File: rtl/lmem_rd_return.sv
// Fixed-latency read-return pipe: carries a per-client valid from the crd cycle to rvalidK.
module lmem_rd_return #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic issue,
  input  logic owner,
  output logic rvalid0,
  output logic rvalid1
);
  logic [RD_LAT-1:0] pipe0, pipe1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe0 <= '0;
      pipe1 <= '0;
    end else begin
      pipe0[0] <= issue & ~owner;
      pipe1[0] <= issue & owner;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe0[i] <= pipe0[i-1];
        pipe1[i] <= pipe1[i-1];
      end
    end
  end

  assign rvalid0 = pipe0[RD_LAT-1];
  assign rvalid1 = pipe1[RD_LAT-1];
endmodule

// File: rtl/lmem_port_arbiter.sv
// Round-robin, burst-locking arbiter sharing one layer-memory port between two clients.
module lmem_port_arbiter
  import lmem_pkg::*;
#(
  parameter int AW        = LMEM_AW,
  parameter int DW        = LMEM_DW,
  parameter int MAX_BURST = 16,
  parameter int RD_LAT    = 1
) (
  input logic               clk,
  input logic               reset,
  lmem_port_arbiter_if.slave bus
);
  localparam int BCW = $clog2(MAX_BURST);

  logic [0:0]     state;
  logic           owner, rr_ptr;
  logic [BCW-1:0] beat_cnt;

  lmem_beat_t beat0, beat1, own_beat;
  logic       own_req, accept, cnt_full, rel_now;

  assign beat0    = {bus.we0, bus.sel0, bus.addr0, bus.wdata0, bus.last0};
  assign beat1    = {bus.we1, bus.sel1, bus.addr1, bus.wdata1, bus.last1};
  assign own_beat = owner ? beat1 : beat0;
  assign own_req  = owner ? bus.req1 : bus.req0;
  assign accept   = (state == ARB_OWN) && own_req;
  assign cnt_full = (beat_cnt == BCW'(MAX_BURST - 1));
  // Dropping req also releases, so the owner cannot stall the port.
  assign rel_now  = (state == ARB_OWN) && (!own_req || own_beat.last || cnt_full);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ARB_IDLE;
      owner    <= 1'b0;
      rr_ptr   <= 1'b0;
      beat_cnt <= '0;
    end else if (state == ARB_IDLE) begin
      if (bus.req0 || bus.req1) begin
        state <= ARB_OWN;
        owner <= (bus.req0 && bus.req1) ? rr_ptr : bus.req1;
      end
    end else if (rel_now) begin
      state    <= ARB_IDLE;
      rr_ptr   <= ~owner;
      beat_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  logic          cwr_q, crd_q, csel_q, rd_owner_q;
  logic [AW-1:0] caddr_wr_q, caddr_rd_q;
  logic [DW-1:0] cdata_wr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cwr_q      <= 1'b0;
      crd_q      <= 1'b0;
      csel_q     <= LMEM_L0;
      rd_owner_q <= 1'b0;
      caddr_wr_q <= '0;
      caddr_rd_q <= '0;
      cdata_wr_q <= '0;
    end else begin
      cwr_q <= accept && own_beat.we;
      crd_q <= accept && !own_beat.we;
      if (accept) begin
        csel_q <= own_beat.sel;
        if (own_beat.we) begin
          caddr_wr_q <= own_beat.addr;
          cdata_wr_q <= own_beat.wdata;
        end else begin
          caddr_rd_q <= own_beat.addr;
          rd_owner_q <= owner;
        end
      end
    end
  end

  // Return routing follows the owner captured with the read, not the live grant.
  lmem_rd_return #(.RD_LAT(RD_LAT)) u_rd_return (
    .clk     (clk),
    .reset   (reset),
    .issue   (crd_q),
    .owner   (rd_owner_q),
    .rvalid0 (bus.rvalid0),
    .rvalid1 (bus.rvalid1)
  );

  assign bus.gnt0      = (state == ARB_OWN) && !owner;
  assign bus.gnt1      = (state == ARB_OWN) && owner;
  assign bus.cwr       = cwr_q;
  assign bus.crd       = crd_q;
  assign bus.csel      = csel_q;
  assign bus.caddr_wr  = caddr_wr_q;
  assign bus.caddr_rd  = caddr_rd_q;
  assign bus.cdata_wr  = cdata_wr_q;
  assign bus.rdata0    = bus.cdata_rd;
  assign bus.rdata1    = bus.cdata_rd;
  assign bus.arb_state = state;
endmodule
